// File: rtl/sorted_insert.sv
// sorted_insert
//   Inserts one value per request into a RAM-resident list kept in ascending
//   unsigned order. The search walks down from the top of the list and shifts
//   each larger entry up one slot until the insertion point is found, so the
//   list is sorted again when the insert finishes.
//
// Ports
//   clk       sole clock, rising edge
//   reset     asynchronous, active-high
//   start     level request to insert valueIn (one insert per high level)
//   clear     empties the list when sampled in IDLE (wins over start)
//   valueIn   value to insert, latched when start is accepted
//   rdata     RAM read data, valid one cycle after addr is presented
//   addr      RAM address for both reads and writes
//   wren      RAM write enable, one-cycle pulse per write
//   wdata     RAM write data
//   count     number of valid entries (0..2**ADDR_W)
//   busy      high while an insert is in progress (READ, CMP, WRITE)
//   done      high while in DONE
//   full      list holds 2**ADDR_W entries
//   rejected  high in DONE when the insert was refused because the list was full
module sorted_insert #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clear,
  input  logic [DATA_W-1:0] valueIn,
  input  logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] addr,
  output logic              wren,
  output logic [DATA_W-1:0] wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              rejected
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CMP,
    WRITE,
    DONE
  } state_t;

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  state_t              state;
  logic [ADDR_W-1:0]   i;
  logic [ADDR_W-1:0]   pos;
  logic [DATA_W-1:0]   value;

  // Equal entries are not shifted, so duplicates land after existing equals.
  logic                shift_up;
  assign shift_up = (rdata > value);

  assign full = (count == CAPACITY);
  assign busy = (state == READ) || (state == CMP) || (state == WRITE);
  assign done = (state == DONE);

  // Control FSM. The walk exits at i==0 before any decrement, so i can never
  // wrap; pos is the slot the latched value finally goes into.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      i        <= '0;
      pos      <= '0;
      value    <= '0;
      rejected <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            count <= '0;
          end else if (start) begin
            if (full) begin
              rejected <= 1'b1;
              state    <= DONE;
            end else if (count == '0) begin
              value <= valueIn;
              pos   <= '0;
              state <= WRITE;
            end else begin
              value <= valueIn;
              i     <= count[ADDR_W-1:0] - 1'b1;
              state <= READ;
            end
          end
        end
        READ: begin
          state <= CMP;
        end
        CMP: begin
          if (shift_up) begin
            if (i == '0) begin
              pos   <= '0;
              state <= WRITE;
            end else begin
              i     <= i - 1'b1;
              state <= READ;
            end
          end else begin
            pos   <= i + 1'b1;
            state <= WRITE;
          end
        end
        WRITE: begin
          count <= count + 1'b1;
          state <= DONE;
        end
        DONE: begin
          // Waiting for start to drop makes one start level give one insert.
          if (!start) begin
            rejected <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // RAM port decode. The shift write in CMP has to use rdata in the same
  // cycle it arrives, so the port is decoded from the registered state
  // rather than registered again; idle cycles park addr/wdata at zero.
  always_comb begin
    addr  = '0;
    wren  = 1'b0;
    wdata = '0;
    case (state)
      READ: begin
        addr = i;
      end
      CMP: begin
        if (shift_up) begin
          wren  = 1'b1;
          addr  = i + 1'b1;
          wdata = rdata;
        end
      end
      WRITE: begin
        wren  = 1'b1;
        addr  = pos;
        wdata = value;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_sorted_insert.sv
// tb_sorted_insert
//   Bench for sorted_insert with a 32x8 synchronous RAM model (1-cycle read).
//   Stimulus pushes the expected RAM writes and done results into queues; a
//   monitor pops and compares them whenever the DUT writes or raises done.
module tb_sorted_insert;

  logic       clk;
  logic       reset;
  logic       start;
  logic       clear;
  logic [7:0] value_in;
  logic [7:0] rdata;
  logic [4:0] addr;
  logic       wren;
  logic [7:0] wdata;
  logic [5:0] count;
  logic       busy;
  logic       done;
  logic       full;
  logic       rejected;

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    int         cyc;
    logic [5:0] cnt;
    logic       rej;
  } done_t;

  wr_t   wr_q[$];
  done_t done_q[$];

  logic [7:0] mem [32];
  int         cycle;
  int         checks;
  int         errors;
  logic       prev_done;

  sorted_insert #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .clear    (clear),
    .valueIn  (value_in),
    .rdata    (rdata),
    .addr     (addr),
    .wren     (wren),
    .wdata    (wdata),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .full     (full),
    .rejected (rejected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: write on wren, read data registered from addr.
  always @(posedge clk) begin
    if (wren) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic pushWrite(input logic [4:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    wr_q.push_back(w);
  endtask

  // Monitor: compares every RAM write and every rising done against the queues.
  initial prev_done = 1'b0;
  always @(negedge clk) begin
    wr_t   w;
    done_t e;
    if (!reset) begin
      if (wren) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedWrite: got addr %0h data %0h expected no write", addr, wdata);
        end else begin
          w = wr_q.pop_front();
          checkOutput("writeAddr", 32'(addr), 32'(w.a));
          checkOutput("writeData", 32'(wdata), 32'(w.d));
        end
      end
      if (done && !prev_done) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedDone: got done=1 expected none");
        end else begin
          e = done_q.pop_front();
          checkOutput("doneCycle", 32'(cycle), 32'(e.cyc));
          checkOutput("doneCount", 32'(count), 32'(e.cnt));
          checkOutput("doneRejected", 32'(rejected), 32'(e.rej));
        end
      end
    end
    prev_done = done;
  end

  // One insert request: start high with value, expected done latency counted
  // with the sampling edge as cycle 1, then hold start and release.
  task automatic applyStimulus(input logic [7:0] v, input int lat, input logic [5:0] cnt,
                               input logic rej, input int hold);
    done_t e;
    bit    seen;
    @(negedge clk);
    start    = 1'b1;
    value_in = v;
    e.cyc    = cycle + lat;
    e.cnt    = cnt;
    e.rej    = rej;
    done_q.push_back(e);
    @(posedge clk);
    #1 value_in = ~v;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL doneTimeout: got no done expected done for value %0h", v);
    end
    repeat (hold) @(negedge clk);
    if (hold > 0) begin
      checkOutput("doneHeld", 32'(done), 1);
      checkOutput("countHeld", 32'(count), 32'(cnt));
      checkOutput("rejectedHeld", 32'(rejected), 32'(rej));
    end
    start = 1'b0;
    @(negedge clk);
    checkOutput("doneReleased", 32'(done), 0);
    checkOutput("rejectedReleased", 32'(rejected), 0);
    checkOutput("busyReleased", 32'(busy), 0);
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    start    = 1'b0;
    clear    = 1'b0;
    value_in = 8'h00;
    checks   = 0;
    errors   = 0;

    repeat (2) @(negedge clk);
    checkOutput("resetAddr", 32'(addr), 0);
    checkOutput("resetWren", 32'(wren), 0);
    checkOutput("resetCount", 32'(count), 0);
    checkOutput("resetBusy", 32'(busy), 0);
    checkOutput("resetDone", 32'(done), 0);
    checkOutput("resetFull", 32'(full), 0);
    reset = 1'b0;

    // Empty insert, with start held after done to confirm a single insert.
    $display("[TB] empty insert");
    pushWrite(5'd0, 8'h21);
    applyStimulus(8'h21, 2, 6'd1, 1'b0, 10);

    // Build {05,19,21}, then the middle insert of 0x10.
    $display("[TB] middle insert");
    pushWrite(5'd1, 8'h21);
    pushWrite(5'd0, 8'h05);
    applyStimulus(8'h05, 4, 6'd2, 1'b0, 0);
    pushWrite(5'd2, 8'h21);
    pushWrite(5'd1, 8'h19);
    applyStimulus(8'h19, 6, 6'd3, 1'b0, 0);
    pushWrite(5'd3, 8'h21);
    pushWrite(5'd2, 8'h19);
    pushWrite(5'd1, 8'h10);
    applyStimulus(8'h10, 8, 6'd4, 1'b0, 0);
    checkOutput("mid0", 32'(mem[0]), 'h05);
    checkOutput("mid1", 32'(mem[1]), 'h10);
    checkOutput("mid2", 32'(mem[2]), 'h19);
    checkOutput("mid3", 32'(mem[3]), 'h21);

    // Clear in IDLE with four entries: no RAM activity expected.
    $display("[TB] clear");
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkOutput("clearCount", 32'(count), 0);
    checkOutput("clearBusy", 32'(busy), 0);

    // Bottom insert and duplicate.
    $display("[TB] bottom and duplicate");
    pushWrite(5'd0, 8'h05);
    applyStimulus(8'h05, 2, 6'd1, 1'b0, 0);
    pushWrite(5'd1, 8'h19);
    applyStimulus(8'h19, 4, 6'd2, 1'b0, 0);
    pushWrite(5'd2, 8'h19);
    pushWrite(5'd1, 8'h05);
    pushWrite(5'd0, 8'h00);
    applyStimulus(8'h00, 6, 6'd3, 1'b0, 0);
    pushWrite(5'd3, 8'h19);
    applyStimulus(8'h19, 4, 6'd4, 1'b0, 0);
    checkOutput("dup0", 32'(mem[0]), 'h00);
    checkOutput("dup1", 32'(mem[1]), 'h05);
    checkOutput("dup2", 32'(mem[2]), 'h19);
    checkOutput("dup3", 32'(mem[3]), 'h19);

    // Reset during CMP of a shifting insert.
    $display("[TB] reset mid-shift");
    pushWrite(5'd4, 8'h19);
    @(negedge clk);
    start    = 1'b1;
    value_in = 8'h01;
    @(negedge clk);
    checkOutput("midReadBusy", 32'(busy), 1);
    checkOutput("midReadAddr", 32'(addr), 3);
    @(negedge clk);
    checkOutput("midCmpWren", 32'(wren), 1);
    #1 reset = 1'b1;
    start = 1'b0;
    #1;
    checkOutput("asyncAddr", 32'(addr), 0);
    checkOutput("asyncWren", 32'(wren), 0);
    checkOutput("asyncWdata", 32'(wdata), 0);
    checkOutput("asyncCount", 32'(count), 0);
    checkOutput("asyncBusy", 32'(busy), 0);
    checkOutput("asyncDone", 32'(done), 0);
    checkOutput("asyncFull", 32'(full), 0);
    checkOutput("asyncRejected", 32'(rejected), 0);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midShiftWriteSeen", 32'(wr_q.size()), 0);

    // Fill with 0x1F down to 0x00: every insert shifts the whole list.
    $display("[TB] fill to full");
    for (int v = 31; v >= 0; v--) begin
      n = 31 - v;
      for (int j = n - 1; j >= 0; j--) pushWrite(5'(j + 1), 8'(v + 1 + j));
      pushWrite(5'd0, 8'(v));
      applyStimulus(8'(v), 2 * n + 2, 6'(n + 1), 1'b0, 0);
    end
    checkOutput("fullFlag", 32'(full), 1);
    checkOutput("fullCount", 32'(count), 32);
    for (int j = 0; j < 32; j++) checkOutput($sformatf("fullList%0d", j), 32'(mem[j]), 32'(j));

    // 33rd insert is refused; start held to confirm it stays in DONE.
    $display("[TB] rejected insert");
    applyStimulus(8'h40, 1, 6'd32, 1'b1, 10);
    checkOutput("rejectCount", 32'(count), 32);

    repeat (2) @(negedge clk);
    checkOutput("writesPending", 32'(wr_q.size()), 0);
    checkOutput("donesPending", 32'(done_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sorted_insert.md
SORTED_INSERT -- requirements
Module: sorted_insert

Interface
REQ-001 Parameters SHALL be:
- DATA_W, 8, width of each stored value
- ADDR_W, 5, RAM address width; capacity is 2**ADDR_W = 32 entries

REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; one clock, reset asynchronous and active-high
- start  in  1  level request: insert valueIn; already synchronized by caller
- clear  in  1  synchronous; empties the list when sampled in IDLE
- valueIn  in  DATA_W  value to insert; latched when start is accepted
- rdata  in  DATA_W  RAM read data; valid exactly one cycle after addr is presented
- addr  out  ADDR_W  RAM address, for both read and write
- wren  out  1  RAM write enable, one-cycle pulse per write
- wdata  out  DATA_W  RAM write data
- count  out  ADDR_W+1  number of valid entries, 0..32
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high while in DONE
- full  out  1  count == 32
- rejected  out  1  high in DONE when the insert was refused because the list was full

Function
REQ-003 The block SHALL keep RAM[0..count-1] sorted ascending (unsigned), forming the sorted table the binary searcher reads.
REQ-004 States SHALL be IDLE, READ, CMP, WRITE, DONE.

REQ-005 IDLE transitions:
- clear=1: count<=0, remain in IDLE; clear has priority over start.
- start=1, count==32: rejected<=1, go to DONE; no RAM write.
- start=1, count==0: latch valueIn, pos<=0, go to WRITE.
- start=1, otherwise: latch valueIn, i<=count-1, go to READ.

REQ-006 READ SHALL drive addr=i, wren=0, then go to CMP.

REQ-007 CMP SHALL compare rdata against the latched value:
- rdata > value: drive wren=1, addr=i+1, wdata=rdata (shift up one slot).
  - If i==0: pos<=0, go to WRITE.
  - Else: i<=i-1, go to READ.
- rdata <= value: pos<=i+1, go to WRITE, no write this cycle.
- Equal values SHALL NOT be shifted, so a duplicate is inserted after existing equals.

REQ-008 WRITE SHALL drive wren=1, addr=pos, wdata=latched value, set count<=count+1, then go to DONE.

REQ-009 DONE SHALL hold done=1 and ignore valueIn. When start==0 it SHALL clear rejected and return to IDLE, so one start level yields exactly one insert.

REQ-010 Latency from the start-sampling edge to done=1, with k = number of entries shifted:
- count==0: 2 cycles.
- k==count: 2k+2 cycles.
- Otherwise: 2k+4 cycles.
- Full (rejected): 1 cycle.

REQ-011 wren SHALL be 0 in IDLE, READ and DONE. At most one RAM access SHALL occur per cycle.

REQ-012 The index i SHALL never underflow. The exit at i==0 is taken before any decrement.

REQ-013 valueIn changes after acceptance SHALL have no effect on the insert in progress.

REQ-014 addr and wdata SHALL be 0 when wren=0 and the state is not READ.

Reset
REQ-015 Asserting reset SHALL immediately force:
- state = IDLE
- count = 0
- i, pos and the latched value = 0
- addr = 0, wren = 0, wdata = 0
- busy = 0, done = 0, full = 0, rejected = 0

REQ-016 Reset mid-operation SHALL abandon the insert. RAM contents are then don't-care, because count=0 marks the list empty.

REQ-017 Operation SHALL resume on the first rising edge after reset deasserts.

Verification
REQ-018 The bench SHALL model a 32x8 synchronous RAM with 1-cycle read latency and cover:
- Empty insert: reset, start with valueIn=0x21 -> one write at addr 0 data 0x21; done 2 cycles after start sampled; count=1.
- Middle insert: list {0x05,0x19,0x21}, insert 0x10 -> writes (addr 3,0x21), (addr 2,0x19), (addr 1,0x10); count=4; final list {05,10,19,21}; done at cycle 8.
- Bottom insert and duplicate: insert 0x00 into {05,19} -> list {00,05,19}; then insert 0x19 -> placed at addr 3 with no shift.
- Full: insert 32 values 0x1F down to 0x00 -> list ascending 0x00..0x1F, full=1; a 33rd start -> rejected=1, done after 1 cycle, no wren pulses, count stays 32.
- Handshake: hold start high for 10 cycles after done -> exactly one insert; deassert start -> IDLE, done=0, rejected cleared.
- Reset mid-shift and clear: assert reset during CMP -> all outputs 0 asynchronously, count=0; clear in IDLE with count=4 -> count=0 next edge, no RAM activity.
